// File: rtl/data_sram_if.sv
// Data-SRAM request/response bundle shared by the memory-access requester
// (master) and the on-chip data memory (slave).
interface data_sram_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_ready;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  data_sram_ready
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output data_sram_ready
  );
endinterface

// File: rtl/data_sram_resp.sv
// Single-port word-organised data SRAM with byte enables and a 1-cycle read-first read path.
// Optional DSRAM_INIT_CLEAR_EN: post-reset sweep writes INIT_VAL to every word while ready=0.
module data_sram_resp #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  data_sram_if.slave   bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;

  logic [ADDR_W-1:0] req_idx_c;
  logic              accept_c;

  // Shared write port, fed either by the clear sweep or by an accepted request
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_idx_c;
  logic [LANES-1:0]  wr_lanes_c;
  logic [DATA_W-1:0] wr_data_c;

  assign req_idx_c = bus.data_sram_addr[ADDR_W+1:2];
  assign accept_c  = bus.data_sram_en & ready_q;

  // Byte offset and bits above the array size are don't-care for word addressing
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

`ifdef DSRAM_INIT_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clearing_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= (state_d == ST_IDLE);
    end
  end

  // Sweep one word per cycle; the last word is written on the cycle that leaves CLEAR
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clearing_c = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing_c = 1'b1;
        clr_cnt_d  = ADDR_W'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_comb begin
    wr_en_c    = 1'b0;
    wr_idx_c   = req_idx_c;
    wr_lanes_c = bus.data_sram_wen;
    wr_data_c  = bus.data_sram_wdata;
    if (clearing_c) begin
      wr_en_c    = 1'b1;
      wr_idx_c   = clr_cnt_q;
      wr_lanes_c = '1;
      wr_data_c  = INIT_VAL;
    end else if (accept_c && (bus.data_sram_wen != '0)) begin
      wr_en_c = 1'b1;
    end
  end
`else
  logic [DATA_W-1:0] unused_init;
  assign unused_init = INIT_VAL;

  assign ready_q = 1'b1;

  always_comb begin
    wr_en_c    = accept_c && (bus.data_sram_wen != '0);
    wr_idx_c   = req_idx_c;
    wr_lanes_c = bus.data_sram_wen;
    wr_data_c  = bus.data_sram_wdata;
  end
`endif

  // Array storage is never reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_lanes_c[i]) begin
          mem[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
        end
      end
    end
  end

  // Read-first: writes also return the word's previous contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (accept_c) begin
      rdata_q <= mem[req_idx_c];
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign bus.data_sram_ready = ready_q;

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the data-SRAM interface: the memory-access requester drives data_sram_en/wen/addr/wdata; the memory stage consumes data_sram_rdata exactly one cycle later.
- Single-port, word-organised, synchronous RAM with per-byte write enables and a registered read path.
- Adds a ready indication so the pipeline can hold requests off while the array is unavailable.
- Used as the on-chip data memory in simulation and FPGA builds.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W words of 32 bits.
- INIT_VAL, 32'h0000_0000, value written to every word by the post-reset clear sweep (only with the optional feature).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_sram_en  input  1  request strobe for this cycle.
- data_sram_wen  input  4  byte write enables; wen[i] writes wdata[8i+7:8i]; 4'b0000 means read.
- data_sram_addr  input  32  byte address; bits [ADDR_W+1:2] select the word; [1:0] and [31:ADDR_W+2] ignored.
- data_sram_wdata  input  32  write data, byte lanes aligned to wen.
- data_sram_rdata  output  32  registered read data.
- data_sram_ready  output  1  array accepts requests this cycle.

Behaviour:
Reset:
- Asynchronous assertion forces data_sram_rdata = 0.
- data_sram_ready = 1 without the optional feature; 0 with it.
- Array contents are not reset.

Accepted request:
- A request is accepted on a rising edge when data_sram_en=1 and data_sram_ready=1.
- Requests while ready=0 are dropped: no write, rdata unchanged.
- Any en=1 cycle is a request, whether or not wen=0.

Read (wen=4'b0000):
- rdata updates on the accepting edge to mem[word], so it is valid in the cycle after the request.
- Latency is exactly 1 cycle.

Write (wen != 0):
- Only enabled byte lanes of mem[word] are updated on the accepting edge.
- Read-first: rdata also updates on that edge to the word's contents before the write.
- The written value is visible to a read accepted on the next cycle.

Idle:
- With en=0, rdata holds its last value indefinitely.

Back-to-back and addressing:
- Back-to-back requests are accepted every cycle with no bubble.
- A write at cycle N followed by a read of the same word at N+1 returns the new data at N+2.
- Word index wraps modulo 2**ADDR_W: addr 0x0000_1000 aliases 0x0 when ADDR_W=10.
- Unaligned addresses are not checked; the low 2 bits are ignored.

Optional Feature:
- Macro: DSRAM_INIT_CLEAR_EN.
- Defined: two-state FSM.
  - CLEAR: entered on reset; a clear counter of width ADDR_W starts at 0.
    - Each cycle writes INIT_VAL to mem[counter] and increments the counter.
    - ready=0 throughout; external requests are ignored.
    - When the counter reaches 2**ADDR_W-1, that final word is written and the FSM moves to IDLE.
    - The sweep takes exactly 2**ADDR_W cycles.
  - IDLE: ready=1; normal operation.
  - Reset asserted mid-sweep restarts CLEAR from word 0.
  - rdata stays 0 until the first accepted read.
- Undefined: no FSM, no counter; ready is tied to 1 after reset; memory contents are X until written.

Test Plan:
1. Write, then read back:
   - Stimulus: ready=1; write addr 0x10, wen 4'hF, wdata 0xDEADBEEF; next cycle read addr 0x10.
   - Required response: rdata = 0xDEADBEEF exactly one cycle after the read.
2. Byte-lane merge:
   - Stimulus: word 0x20 holds 0x11223344; write wen 4'b0101, wdata 0xAABBCCDD; then read 0x20.
   - Required response: 0x11BB33DD.
3. Read-first on write, then hold:
   - Stimulus: word 0x30 holds 0x0000_00A5; write 0xFFFF_FFFF with wen 4'hF.
   - Required response: rdata = 0x0000_00A5 the next cycle; idle cycles keep 0x0000_00A5.
4. Wrap-around alias:
   - Stimulus: ADDR_W=10; write 0x12345678 to addr 0x1004; read addr 0x0004.
   - Required response: 0x12345678.
5. Clear sweep (DSRAM_INIT_CLEAR_EN, ADDR_W=4):
   - Stimulus: release reset; drive a write attempt on cycle 3.
   - Required response: ready=0 for 16 cycles and then 1; reading words 0..15 returns 0; the cycle-3 write is dropped.
6. Reset during sweep (DSRAM_INIT_CLEAR_EN, ADDR_W=4):
   - Stimulus: re-assert reset at sweep cycle 7.
   - Required response: rdata=0 immediately (asynchronous); after release, ready stays 0 for a full 16 cycles.
